// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared constants and state encoding for the UART blocks |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;
    localparam int unsigned DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_sync : two-flop synchronizer with parameterized reset value   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic [1:0] sync_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], i_Async};
        end
    end

    assign o_Sync = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_ctrl : 8N1 UART receiver with mid-bit sampling and framing |
// | error detection. Rev 1.0                                           |
// +--------------------------------------------------------------------+
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_RX_Active,
    output logic                 o_RX_Frame_Err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 dv_q;
    logic [DATA_BITS-1:0] byte_q;
    logic                 active_q;
    logic                 err_q;

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Async (i_RX_Serial),
        .o_Sync  (rx_s)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            dv_q      <= 1'b0;
            byte_q    <= '0;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    // Edge, not level: a line stuck low must not retrigger.
                    if (rx_prev_q && !rx_s) begin
                        state_q  <= START;
                        active_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_BIT) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= DATA;
                        end else begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == IDX_LAST) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= CLEANUP;
                        active_q <= 1'b0;
                        if (rx_s) begin
                            byte_q <= shift_q;
                            dv_q   <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CLEANUP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_RX_DV        = dv_q;
    assign o_RX_Byte      = byte_q;
    assign o_RX_Active    = active_q;
    assign o_RX_Frame_Err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_rx_ctrl : directed frames against an event-list model      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_rx_ctrl;

    localparam int CLKS = 217;
    localparam int HALF = (CLKS - 1) / 2;
    localparam int LAT  = 2 + HALF + 9 * CLKS + 1;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       drv_line = 1'b1;
    logic       use_tx   = 1'b0;
    logic       tx_line  = 1'b1;
    logic       tx_go    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic [8:0] tx_sh    = '1;
    int         tx_bits  = 0;
    int         tx_cnt   = 0;
    logic       rx_line;

    logic       dv;
    logic [7:0] rx_byte;
    logic       active;
    logic       ferr;

    assign rx_line = use_tx ? tx_line : drv_line;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (CLKS)
    ) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_RX_Serial    (rx_line),
        .o_RX_DV        (dv),
        .o_RX_Byte      (rx_byte),
        .o_RX_Active    (active),
        .o_RX_Frame_Err (ferr)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple 8N1 transmitter used for the loopback case.
    always @(posedge clk) begin
        if (tx_go) begin
            tx_line <= 1'b0;
            tx_sh   <= {1'b1, tx_data};
            tx_bits <= 9;
            tx_cnt  <= CLKS - 1;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
        end else if (tx_bits > 0) begin
            tx_line <= tx_sh[0];
            tx_sh   <= {1'b1, tx_sh[8:1]};
            tx_bits <= tx_bits - 1;
            tx_cnt  <= CLKS - 1;
        end
    end

    typedef struct { int at; bit is_err; logic [7:0] data; } ev_t;
    typedef struct { int lo; int hi; } win_t;
    ev_t  evq[$];
    win_t winq[$];

    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_byte = 8'h00;
    int         dv_cyc[$];
    logic [7:0] dv_val[$];
    int         err_cnt = 0;
    int         act_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A frame whose line falls before edge e0 yields its result LAT edges later
    // and keeps the receiver busy from e0+2 until the stop sample.
    function automatic void expect_frame(input int e0, input logic [7:0] d, input bit stop_ok);
        evq.push_back('{e0 + LAT, !stop_ok, d});
        winq.push_back('{e0 + 2, e0 + LAT - 1});
    endfunction

    function automatic void expect_glitch(input int e0);
        winq.push_back('{e0 + 2, e0 + 2 + HALF});
    endfunction

    always @(negedge clk) begin : cmp
        logic e_dv, e_err, e_act;
        e_dv  = 1'b0;
        e_err = 1'b0;
        e_act = 1'b0;
        if (!rst_n) begin
            evq.delete();
            winq.delete();
            m_byte = 8'h00;
        end else begin
            if (evq.size() > 0 && evq[0].at == cyc) begin
                if (evq[0].is_err) begin
                    e_err = 1'b1;
                end else begin
                    e_dv   = 1'b1;
                    m_byte = evq[0].data;
                end
                void'(evq.pop_front());
            end
            while (winq.size() > 0 && winq[0].hi < cyc) void'(winq.pop_front());
            if (winq.size() > 0 && winq[0].lo <= cyc) e_act = 1'b1;
        end
        check("dv", 32'(dv), 32'(e_dv));
        check("frame_err", 32'(ferr), 32'(e_err));
        check("active", 32'(active), 32'(e_act));
        check("byte", 32'(rx_byte), 32'(m_byte));
        check("dv_err_overlap", 32'(dv & ferr), 32'd0);
        if (dv) begin
            dv_cyc.push_back(cyc);
            dv_val.push_back(rx_byte);
        end
        if (ferr) err_cnt++;
        if (active) act_cnt++;
    end

    // Caller must be at a falling clock edge; the line changes immediately.
    task automatic drive_frame(input logic [7:0] d, input bit stop);
        drv_line = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drv_line = d[i];
            repeat (CLKS) @(negedge clk);
        end
        drv_line = stop;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dv"}, 32'(dv), 32'd0);
        check({tag, "_byte"}, 32'(rx_byte), 32'd0);
        check({tag, "_active"}, 32'(active), 32'd0);
        check({tag, "_ferr"}, 32'(ferr), 32'd0);
    endtask

    initial begin : watchdog
        #(60000 * 40);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin : stim
        int e0, n0, a0, f0;

        #1 rst_n = 1'b0;
        #5 check_outputs_zero("reset");
        repeat (5) @(negedge clk);
        #5 rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Byte 0xAA
        n0 = dv_cyc.size();
        e0 = cyc + 1;
        expect_frame(e0, 8'hAA, 1'b1);
        drive_frame(8'hAA, 1'b1);
        repeat (50) @(negedge clk);
        check("aa_count", 32'(dv_cyc.size() - n0), 32'd1);
        if (dv_cyc.size() > n0) begin
            check("aa_latency", 32'(dv_cyc[n0] - e0), 32'd2064);
            check("aa_byte", 32'(dv_val[n0]), 32'hAA);
        end

        // 50-cycle low glitch
        n0 = dv_cyc.size();
        f0 = err_cnt;
        a0 = act_cnt;
        e0 = cyc + 1;
        expect_glitch(e0);
        drv_line = 1'b0;
        repeat (50) @(negedge clk);
        drv_line = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_active_cycles", 32'(act_cnt - a0), 32'd109);
        check("glitch_dv", 32'(dv_cyc.size() - n0), 32'd0);
        check("glitch_ferr", 32'(err_cnt - f0), 32'd0);

        // 0x3F with bad stop bit, then line stuck low, then 0x55
        n0 = dv_cyc.size();
        f0 = err_cnt;
        e0 = cyc + 1;
        expect_frame(e0, 8'h3F, 1'b0);
        drive_frame(8'h3F, 1'b0);
        repeat (3000) @(negedge clk);
        check("ferr_count", 32'(err_cnt - f0), 32'd1);
        check("ferr_byte_kept", 32'(rx_byte), 32'hAA);
        check("stuck_low_dv", 32'(dv_cyc.size() - n0), 32'd0);
        drv_line = 1'b1;
        repeat (50) @(negedge clk);
        e0 = cyc + 1;
        expect_frame(e0, 8'h55, 1'b1);
        drive_frame(8'h55, 1'b1);
        repeat (50) @(negedge clk);
        check("b55_count", 32'(dv_cyc.size() - n0), 32'd1);
        if (dv_cyc.size() > n0) check("b55_byte", 32'(dv_val[n0]), 32'h55);

        // 0x00 then 0xFF with no idle gap
        n0 = dv_cyc.size();
        e0 = cyc + 1;
        expect_frame(e0, 8'h00, 1'b1);
        expect_frame(e0 + 10 * CLKS, 8'hFF, 1'b1);
        drive_frame(8'h00, 1'b1);
        drive_frame(8'hFF, 1'b1);
        repeat (50) @(negedge clk);
        check("b2b_count", 32'(dv_cyc.size() - n0), 32'd2);
        if (dv_cyc.size() > n0 + 1) begin
            check("b2b_spacing", 32'(dv_cyc[n0 + 1] - dv_cyc[n0]), 32'd2170);
            check("b2b_first", 32'(dv_val[n0]), 32'h00);
            check("b2b_second", 32'(dv_val[n0 + 1]), 32'hFF);
        end

        // Reset during data bit 4 of 0xC3, released while the line is high
        n0 = dv_cyc.size();
        f0 = err_cnt;
        e0 = cyc + 1;
        winq.push_back('{e0 + 2, 32'h7fff_ffff});
        fork
            drive_frame(8'hC3, 1'b1);
            begin
                repeat (5 * CLKS + CLKS / 2) @(negedge clk);
                #5 rst_n = 1'b0;
                #1 check_outputs_zero("midframe_reset");
                repeat (2 * CLKS) @(negedge clk);
                #5 rst_n = 1'b1;
            end
        join
        repeat (50) @(negedge clk);
        check("c3_no_dv", 32'(dv_cyc.size() - n0), 32'd0);
        check("c3_no_ferr", 32'(err_cnt - f0), 32'd0);
        e0 = cyc + 1;
        expect_frame(e0, 8'h81, 1'b1);
        drive_frame(8'h81, 1'b1);
        repeat (50) @(negedge clk);
        check("b81_count", 32'(dv_cyc.size() - n0), 32'd1);
        if (dv_cyc.size() > n0) check("b81_byte", 32'(dv_val[n0]), 32'h81);

        // Loopback from the transmitter
        n0 = dv_cyc.size();
        f0 = err_cnt;
        use_tx  = 1'b1;
        tx_data = 8'hAA;
        e0 = cyc + 2;
        expect_frame(e0, 8'hAA, 1'b1);
        tx_go = 1'b1;
        @(negedge clk);
        tx_go = 1'b0;
        repeat (10 * CLKS + 100) @(negedge clk);
        use_tx = 1'b0;
        check("loop_count", 32'(dv_cyc.size() - n0), 32'd1);
        if (dv_cyc.size() > n0) check("loop_byte", 32'(dv_val[n0]), 32'hAA);
        check("loop_ferr", 32'(err_cnt - f0), 32'd0);

        check("pending_events", 32'(evq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
